// File: rtl/mitchell_antilog_pkg.sv
// mitchell_antilog_pkg
// Shared definitions for the Mitchell log-to-linear converter.
// Holds the FSM state encoding, the default widths and the derived accumulator
// width used by mitchell_antilog and mitchell_antilog_final.
package mitchell_antilog_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned MA_K_W    = 5;
  localparam int unsigned MA_FRAC_W = 8;
  localparam int unsigned MA_OUT_W  = 16;

  // The accumulator holds the integer part, the fraction and one guard bit
  // that catches a leading one landing just above the result field.
  function automatic int unsigned acc_width(input int unsigned out_w,
                                            input int unsigned frac_w);
    return out_w + frac_w + 1;
  endfunction

  localparam int unsigned MA_ACC_W = acc_width(MA_OUT_W, MA_FRAC_W);

endpackage

// File: rtl/mitchell_antilog_final.sv
// mitchell_antilog_final
// Combinational result formatter for the antilog converter. It extracts the
// integer field from the shifted accumulator, optionally rounds half-up on the
// dropped fraction, and saturates to all ones on overflow.
// Configuration macro: MITCHELL_ANTILOG_ROUND_EN (defined = round half-up,
// undefined = truncate).
// Ports:
//   acc_i  - shifted accumulator {guard, integer field, fraction}
//   ovf_i  - sticky overflow seen during shifting
//   data_o - linear result
//   sat_o  - result was saturated
module mitchell_antilog_final #(
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned ACC_W  = OUT_W + FRAC_W + 1
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic             ovf_i,
  output logic [OUT_W-1:0] data_o,
  output logic             sat_o
);

  logic [OUT_W-1:0] trunc;
  // Bits that the truncating path never reads; the guard bit is already
  // folded into ovf_i by the shifter.
  logic             unused_bits;

  assign trunc       = acc_i[OUT_W+FRAC_W-1:FRAC_W];
  assign unused_bits = ^{acc_i[ACC_W-1], acc_i[FRAC_W-1:0]};

`ifdef MITCHELL_ANTILOG_ROUND_EN
  logic [OUT_W:0] rounded;

  assign rounded = {1'b0, trunc} + {{OUT_W{1'b0}}, acc_i[FRAC_W-1]};

  always_comb begin
    data_o = rounded[OUT_W-1:0];
    sat_o  = 1'b0;
    if (ovf_i || rounded[OUT_W]) begin
      data_o = '1;
      sat_o  = 1'b1;
    end
  end
`else
  always_comb begin
    data_o = trunc;
    sat_o  = 1'b0;
    if (ovf_i) begin
      data_o = '1;
      sat_o  = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mitchell_antilog.sv
// mitchell_antilog
// Iterative log-to-linear converter: computes (1+f)*2^k truncated to an
// integer, one left shift per cycle, with valid/ready handshakes on input and
// output. Optional rounding is selected by MITCHELL_ANTILOG_ROUND_EN (see
// mitchell_antilog_final).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - input handshake
//   in_k, in_frac        - characteristic and mantissa fraction
//   in_zero              - operand was zero, result forced to 0
//   out_valid/out_ready  - output handshake
//   out_data, out_sat    - linear result and saturation flag
module mitchell_antilog
  import mitchell_antilog_pkg::*;
#(
  parameter int unsigned K_W    = MA_K_W,
  parameter int unsigned FRAC_W = MA_FRAC_W,
  parameter int unsigned OUT_W  = MA_OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K_W-1:0]    in_k,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat
);

  localparam int unsigned ACC_W = acc_width(OUT_W, FRAC_W);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [K_W-1:0]     cnt_q;
  logic               ovf_q;
  logic [OUT_W-1:0]   out_data_q;
  logic               out_sat_q;
  logic [OUT_W-1:0]   fmt_data;
  logic               fmt_sat;

  mitchell_antilog_final #(
    .OUT_W  (OUT_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_final (
    .acc_i  (acc_q),
    .ovf_i  (ovf_q),
    .data_o (fmt_data),
    .sat_o  (fmt_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = in_zero ? DONE : SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (in_zero) begin
              out_data_q <= '0;
              out_sat_q  <= 1'b0;
            end else begin
              acc_q <= {{(ACC_W-FRAC_W-1){1'b0}}, 1'b1, in_frac};
              cnt_q <= in_k;
              ovf_q <= 1'b0;
            end
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            acc_q <= acc_q << 1;
            cnt_q <= cnt_q - {{(K_W-1){1'b0}}, 1'b1};
            // Top bit shifting out, or the bit below it landing in the guard
            // position, both mean the result no longer fits.
            ovf_q <= ovf_q | acc_q[ACC_W-1] | acc_q[ACC_W-2];
          end else begin
            out_data_q <= fmt_data;
            out_sat_q  <= fmt_sat;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_data_q;
  assign out_sat  = out_sat_q;

endmodule
